// File: rtl/pc_sequencer_pkg.sv
// rtl/pc_sequencer_pkg.sv - shared encodings and default vectors for the PC sequencer
package pc_sequencer_pkg;

  // Redirect source select; SEL_RSV is decoded as "no redirect".
  typedef enum logic [1:0] {
    SEL_BR  = 2'd0,
    SEL_J   = 2'd1,
    SEL_JR  = 2'd2,
    SEL_RSV = 2'd3
  } redir_sel_e;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_JT_W   = 26;

  localparam logic [31:0] DEF_RESET_VEC = 32'h8000_0000;
  localparam logic [31:0] DEF_IRQ_VEC   = 32'h8000_0004;
  localparam logic [31:0] DEF_EXC_VEC   = 32'h8000_0008;

endpackage

// File: rtl/pc_target_mux.sv
// rtl/pc_target_mux.sv - combinational seq/branch/jump/jr target selection with kernel-bit rules
module pc_target_mux
  import pc_sequencer_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  // JT_W + 3 must not exceed ADDR_W so the jump field never reaches the kernel bit.
  parameter int JT_W   = DEF_JT_W
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic              redir_valid,
  input  logic [1:0]        redir_sel,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_target,
  input  logic [JT_W-1:0]   jt,
  input  logic [ADDR_W-1:0] jr_target,
  output logic [ADDR_W-1:0] seq,
  output logic              redir_hit,
  output logic [ADDR_W-1:0] redir_target
);

  localparam logic [ADDR_W-1:0] LOW_MASK = {1'b0, {(ADDR_W-1){1'b1}}};
  localparam logic [ADDR_W-1:0] MSB_MASK = ~LOW_MASK;
  localparam logic [ADDR_W-2:0] STEP     = (ADDR_W-1)'(4);

  logic              kbit;
  logic [ADDR_W-1:0] kbit_only;
  logic [ADDR_W-1:0] br_addr;
  logic [ADDR_W-1:0] jmp_addr;
  logic [ADDR_W-1:0] jr_addr;
  logic [ADDR_W-1:0] jt_ext;

  assign kbit      = pc[ADDR_W-1];
  assign kbit_only = pc & MSB_MASK;

  // The increment stays in the low field so the kernel bit is never carried into.
  assign seq = {kbit, pc[ADDR_W-2:0] + STEP};

  // Branch targets cannot change privilege: the kernel bit comes from the current pc.
  assign br_addr = (br_target & LOW_MASK) | kbit_only;

  // Jump field is word-aligned and zero-extended below the kernel bit.
  assign jt_ext   = {{(ADDR_W-JT_W-2){1'b0}}, jt, 2'b00};
  assign jmp_addr = jt_ext | kbit_only;

  // User code may never raise the kernel bit; kernel code may drop it to return to user.
  assign jr_addr = kbit ? jr_target : (jr_target & LOW_MASK);

  // Decode the request into a single effective redirect and its target.
  always_comb begin
    redir_hit    = 1'b0;
    redir_target = seq;
    if (redir_valid) begin
      case (redir_sel_e'(redir_sel))
        SEL_BR: begin
          if (br_taken) begin
            redir_hit    = 1'b1;
            redir_target = br_addr;
          end
        end
        SEL_J: begin
          redir_hit    = 1'b1;
          redir_target = jmp_addr;
        end
        SEL_JR: begin
          redir_hit    = 1'b1;
          redir_target = jr_addr;
        end
        default: begin
          redir_hit    = 1'b0;
          redir_target = seq;
        end
      endcase
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - IF-stage program counter with priority redirect, pending latch and epc
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int              ADDR_W    = DEF_ADDR_W,
  parameter int              JT_W      = DEF_JT_W,
  parameter logic [ADDR_W-1:0] RESET_VEC = DEF_RESET_VEC,
  parameter logic [ADDR_W-1:0] IRQ_VEC   = DEF_IRQ_VEC,
  parameter logic [ADDR_W-1:0] EXC_VEC   = DEF_EXC_VEC
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              fetch_ready,
  input  logic              redir_valid,
  input  logic [1:0]        redir_sel,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_target,
  input  logic [JT_W-1:0]   jt,
  input  logic [ADDR_W-1:0] jr_target,
  input  logic              irq,
  input  logic              exc,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic [ADDR_W-1:0] epc,
  output logic              flush,
  output logic              kernel
);

  logic              hold;
  logic              redir_hit;
  logic [ADDR_W-1:0] redir_target;
  logic [ADDR_W-1:0] seq;

  logic              pend_valid;
  logic [ADDR_W-1:0] pend_target;

  logic [ADDR_W-1:0] pc_n;
  logic [ADDR_W-1:0] epc_n;
  logic              pend_valid_n;
  logic [ADDR_W-1:0] pend_target_n;
  logic              flush_n;
  logic [ADDR_W-1:0] next_norm;

  assign hold     = stall | ~fetch_ready;
  assign pc_plus4 = seq;
  assign kernel   = pc[ADDR_W-1];

  pc_target_mux #(
    .ADDR_W (ADDR_W),
    .JT_W   (JT_W)
  ) u_target_mux (
    .pc           (pc),
    .redir_valid  (redir_valid),
    .redir_sel    (redir_sel),
    .br_taken     (br_taken),
    .br_target    (br_target),
    .jt           (jt),
    .jr_target    (jr_target),
    .seq          (seq),
    .redir_hit    (redir_hit),
    .redir_target (redir_target)
  );

  // Unheld next pc: a live redirect beats a pending one, otherwise fall through to seq.
  always_comb begin
    next_norm = seq;
    if (redir_hit) begin
      next_norm = redir_target;
    end else if (pend_valid) begin
      next_norm = pend_target;
    end
  end

  // Priority resolution: exc, then irq, then redirects/pending, then sequential advance.
  always_comb begin
    pc_n          = pc;
    epc_n         = epc;
    pend_valid_n  = pend_valid;
    pend_target_n = pend_target;
    flush_n       = 1'b0;

    if (exc) begin
      // Exceptions are precise even under a stall and discard any pending redirect.
      pc_n         = EXC_VEC;
      epc_n        = seq;
      pend_valid_n = 1'b0;
      flush_n      = 1'b1;
    end else if (irq && !kernel && !hold) begin
      // Return lands where the pipeline would have gone without the interrupt.
      pc_n         = IRQ_VEC;
      epc_n        = next_norm;
      pend_valid_n = 1'b0;
      flush_n      = 1'b1;
    end else if (!hold) begin
      pc_n = next_norm;
      if (redir_hit || pend_valid) begin
        pend_valid_n = 1'b0;
        flush_n      = 1'b1;
      end
    end else if (redir_hit) begin
      // Target is frozen now, relative to the pc that issued it; newer requests overwrite.
      pend_valid_n  = 1'b1;
      pend_target_n = redir_target;
    end
  end

  // Architectural state and the pending-redirect register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc          <= RESET_VEC;
      epc         <= '0;
      pend_valid  <= 1'b0;
      pend_target <= '0;
      flush       <= 1'b0;
    end else begin
      pc          <= pc_n;
      epc         <= epc_n;
      pend_valid  <= pend_valid_n;
      pend_target <= pend_target_n;
      flush       <= flush_n;
    end
  end

endmodule
